// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared arbiter FSM states and index/one-hot helpers
package bus_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_e;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic [15:0] onehot(input int unsigned idx, input int unsigned n);
        logic [16:0] m;
        m = (17'd1 << n) - 17'd1;
        return (16'd1 << idx) & m[15:0];
    endfunction

endpackage

// File: rtl/bus_rr_arbiter_rr_pick.sv
// rr_pick: first set request bit scanning upward from ptr, wrapping at N-1
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int N = 2,
    localparam int IdxW = idx_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic [IdxW-1:0] idx,
    output logic            found
);

    int c;
    logic [N-1:0] sh;

    // descending offsets so the candidate closest to ptr is written last and wins
    always_comb begin
        idx = '0;
        found = 1'b0;
        c = 0;
        sh = '0;
        for (int i = N - 1; i >= 0; i--) begin
            c = int'(ptr) + i;
            c = (c >= N) ? c - N : c;
            sh = req >> c;
            if (sh[0]) begin
                idx = IdxW'(c);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin bus arbiter with locked bursts; BUS_ARB_MAXHOLD_EN caps locked ownership at MaxHold beats
module bus_rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NrHosts = 2,
    parameter int MaxHold = 16,
    localparam int IdxW = idx_width(NrHosts)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NrHosts-1:0] host_req_i,
    input  logic [NrHosts-1:0] host_lock_i,
    output logic [NrHosts-1:0] host_gnt_o,
    output logic [IdxW-1:0]    owner_idx_o,
    output logic               owner_valid_o
);

    if (NrHosts < 1 || NrHosts > 16) begin : g_bad_nrhosts
        $error("NrHosts must be in 1..16");
    end
    if (MaxHold < 1) begin : g_bad_maxhold
        $error("MaxHold must be >= 1");
    end

    arb_state_e state, state_n;
    logic [IdxW-1:0] owner, owner_n, rr_ptr, ptr_n, next_ptr, pick_ptr, win;
    logic [NrHosts-1:0] gnt, gnt_n, pick_req;
    logic found, beat, keep, forced;

    assign next_ptr = (owner == IdxW'(NrHosts - 1)) ? '0 : owner + 1'b1;
    assign beat = (state == ARB_OWN) && host_req_i[owner];

`ifdef BUS_ARB_MAXHOLD_EN
    localparam int HoldW = idx_width(MaxHold);
    logic [HoldW-1:0] hold_cnt;

    assign forced = beat && host_lock_i[owner] && (hold_cnt == HoldW'(MaxHold - 1));

    // count locked beats of the current owner; any release restarts the count
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) hold_cnt <= '0;
        else hold_cnt <= keep ? hold_cnt + 1'b1 : '0;
    end
`else
    assign forced = 1'b0;
`endif

    assign keep = beat && host_lock_i[owner] && !forced;
    assign pick_ptr = (state == ARB_OWN) ? next_ptr : rr_ptr;
    // a forced-out owner may not win the same cycle, which creates the one-cycle gap
    assign pick_req = forced ? host_req_i & ~NrHosts'(onehot(owner, NrHosts)) : host_req_i;

    rr_pick #(.N(NrHosts)) u_pick (
        .req  (pick_req),
        .ptr  (pick_ptr),
        .idx  (win),
        .found(found)
    );

    // next owner: claim from idle, hold while locked, otherwise rotate to the next requester
    always_comb begin
        state_n = state;
        owner_n = owner;
        ptr_n = rr_ptr;
        if (state == ARB_IDLE) begin
            state_n = found ? ARB_OWN : ARB_IDLE;
            owner_n = found ? win : owner;
        end else if (!keep) begin
            ptr_n = next_ptr;
            state_n = found ? ARB_OWN : ARB_IDLE;
            owner_n = found ? win : '0;
        end
        gnt_n = (state_n == ARB_OWN) ? NrHosts'(onehot(owner_n, NrHosts)) : '0;
    end

    // state, owner, pointer and registered one-hot grant
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ARB_IDLE;
            owner <= '0;
            rr_ptr <= '0;
            gnt <= '0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            rr_ptr <= ptr_n;
            gnt <= gnt_n;
        end
    end

    assign host_gnt_o = gnt;
    assign owner_idx_o = owner;
    assign owner_valid_o = (state == ARB_OWN);

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb_bus_rr_arbiter: randomized and directed checks of bus_rr_arbiter (3-host and 1-host) against a behavioural model
module tb_bus_rr_arbiter;

    localparam int N = 3;
    localparam int MH = 4;
`ifdef BUS_ARB_MAXHOLD_EN
    localparam bit MHEN = 1'b1;
`else
    localparam bit MHEN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0] req = '0, lock = '0, gnt;
    logic [1:0] idx;
    logic valid;
    logic req1 = 1'b0, lock1 = 1'b0;
    logic [0:0] gnt1, idx1;
    logic valid1;

    int n_checks = 0;
    int n_pass = 0;

    bit m_own;
    int m_owner, m_ptr, m_hold;
    bit o1;
    int h1;

    always #5 clk = ~clk;

    bus_rr_arbiter #(.NrHosts(N), .MaxHold(MH)) dut (
        .clk_i(clk), .rst_i(rst), .host_req_i(req), .host_lock_i(lock),
        .host_gnt_o(gnt), .owner_idx_o(idx), .owner_valid_o(valid)
    );

    bus_rr_arbiter #(.NrHosts(1), .MaxHold(MH)) dut1 (
        .clk_i(clk), .rst_i(rst), .host_req_i(req1), .host_lock_i(lock1),
        .host_gnt_o(gnt1), .owner_idx_o(idx1), .owner_valid_o(valid1)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int pick(input logic [N-1:0] r, input int start, input int skip);
        int c;
        for (int k = 0; k < N; k++) begin
            c = (start + k) % N;
            if (r[c] && c != skip) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_own = 0; m_owner = 0; m_ptr = 0; m_hold = 0;
        o1 = 0; h1 = 0;
    endtask

    task automatic model_step();
        int w, skip;
        if (!m_own) begin
            w = pick(req, m_ptr, -1);
            if (w >= 0) begin m_own = 1; m_owner = w; m_hold = 0; end
        end else if (req[m_owner] && lock[m_owner] && !(MHEN && m_hold == MH - 1)) begin
            m_hold++;
        end else begin
            skip = (req[m_owner] && lock[m_owner]) ? m_owner : -1;
            m_ptr = (m_owner + 1) % N;
            w = pick(req, m_ptr, skip);
            m_hold = 0;
            m_own = (w >= 0);
            m_owner = (w >= 0) ? w : 0;
        end
        if (!o1) begin o1 = req1; h1 = 0; end
        else if (!req1) begin o1 = 0; h1 = 0; end
        else if (lock1 && MHEN && h1 == MH - 1) begin o1 = 0; h1 = 0; end
        else if (lock1) h1++;
        else h1 = 0;
    endtask

    task automatic compare();
        check("gnt", gnt, m_own ? (1 << m_owner) : 0);
        check("owner_idx", idx, m_owner);
        check("owner_valid", valid, m_own);
        check("rr_ptr", dut.rr_ptr, m_ptr);
        check("gnt1", gnt1, o1);
        check("idx1", idx1, 0);
        check("valid1", valid1, o1);
    endtask

    task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] l, input logic r1, input logic l1);
        req = r; lock = l; req1 = r1; lock1 = l1;
        @(posedge clk);
        model_step();
        #1 compare();
    endtask

    initial begin
        rst = 1'b1;
        model_reset();
        #1 compare();
        @(negedge clk) rst = 1'b0;
        cycle(3'b001, 3'b000, 1'b1, 1'b0);
        check("first_gnt", gnt, 3'b001);
        cycle(3'b000, 3'b000, 1'b0, 1'b0);
        check("drop_gnt", gnt, 3'b000);
        repeat (6) cycle(3'b111, 3'b000, 1'b1, 1'b1);
        cycle(3'b010, 3'b010, 1'b1, 1'b0);
        repeat (3) cycle(3'b011, 3'b010, 1'b1, 1'b0);
        cycle(3'b011, 3'b000, 1'b0, 1'b0);
        cycle(3'b001, 3'b000, 1'b0, 1'b0);
        cycle(3'b100, 3'b100, 1'b0, 1'b0);
        cycle(3'b100, 3'b100, 1'b0, 1'b0);
        cycle(3'b001, 3'b000, 1'b0, 1'b0);
        cycle(3'b000, 3'b000, 1'b0, 1'b0);
        cycle(3'b010, 3'b010, 1'b1, 1'b1);
        cycle(3'b010, 3'b010, 1'b1, 1'b1);
        #2 rst = 1'b1;
        #1 check("rst_async_gnt", gnt, 0);
        check("rst_async_valid", valid, 0);
        check("rst_async_gnt1", gnt1, 0);
        model_reset();
        @(negedge clk) rst = 1'b0;
        cycle(3'b010, 3'b000, 1'b0, 1'b0);
        check("post_rst_gnt", gnt, 3'b010);
        repeat (10) cycle(3'b011, 3'b001, 1'b1, 1'b1);
        repeat (10) cycle(3'b001, 3'b001, 1'b1, 1'b1);
        repeat (500) cycle(N'($urandom), N'($urandom) | N'($urandom), 1'($urandom), ($urandom % 4) != 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
